// File: rtl/product_bcd_converter_if.sv
// Handshake bundle between the multiplier product source and the BCD converter.
// The master drives data and result acceptance. The slave (the converter) returns status and BCD digits.
interface product_bcd_converter_if #(
  parameter int IN_W   = 8,
  parameter int DIGITS = 3
);
  logic                  in_valid;
  logic                  in_ready;
  logic [IN_W-1:0]       in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [4*DIGITS-1:0]   bcd;
  logic                  busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, bcd, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, bcd, busy
  );
endinterface

// File: rtl/product_bcd_converter.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock, with a valid/ready handshake on both sides.
// Optional leading-zero blanking on the latched result is enabled by defining BCD_BLANK_LEADING_ZERO_EN.
module product_bcd_converter #(
  parameter int IN_W   = 8,
  parameter int DIGITS = 3
) (
  input logic                   clk,
  input logic                   rst,
  product_bcd_converter_if.slave bus
);
  localparam int CW = $clog2(IN_W) + 1;
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state_reg, state_next;
  logic [IN_W-1:0] bin_reg, bin_next;
  logic [BW-1:0]   digit_reg, digit_next;
  logic [BW-1:0]   bcd_reg, bcd_next;
  logic [CW-1:0]   count_reg, count_next;
  logic            out_valid_reg, out_valid_next;
  logic            busy_reg, busy_next;

  logic [BW-1:0]   adjusted;
  logic [BW-1:0]   shifted;
  logic [BW-1:0]   display;

  // Add-3 on every digit >= 5 before the shift, so the doubled digit carries correctly.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adjust
      assign adjusted[gi*4 +: 4] = (digit_reg[gi*4 +: 4] >= 4'd5) ?
                                   digit_reg[gi*4 +: 4] + 4'd3 :
                                   digit_reg[gi*4 +: 4];
    end
  endgenerate

  assign shifted = {adjusted[BW-2:0], bin_reg[IN_W-1]};

`ifdef BCD_BLANK_LEADING_ZERO_EN
  logic leading;

  // Scan from the top digit down; digit 0 is never blanked so zero still shows.
  always_comb begin
    display = shifted;
    leading = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (shifted[i*4 +: 4] != 4'd0) leading = 1'b0;
      if (leading) display[i*4 +: 4] = 4'hF;
    end
  end
`else
  assign display = shifted;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      bin_reg       <= '0;
      digit_reg     <= '0;
      bcd_reg       <= '0;
      count_reg     <= '0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bin_reg       <= bin_next;
      digit_reg     <= digit_next;
      bcd_reg       <= bcd_next;
      count_reg     <= count_next;
      out_valid_reg <= out_valid_next;
      busy_reg      <= busy_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    bin_next       = bin_reg;
    digit_next     = digit_reg;
    bcd_next       = bcd_reg;
    count_next     = count_reg;
    out_valid_next = out_valid_reg;
    busy_next      = busy_reg;
    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          bin_next   = bus.in_data;
          digit_next = '0;
          count_next = '0;
          busy_next  = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        bin_next   = bin_reg << 1;
        digit_next = shifted;
        count_next = count_reg + 1'b1;
        // The last shift's digits go straight to the output register.
        if (count_reg == CW'(IN_W - 1)) begin
          bcd_next       = display;
          out_valid_next = 1'b1;
          state_next     = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          out_valid_next = 1'b0;
          busy_next      = 1'b0;
          state_next     = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.out_valid = out_valid_reg;
  assign bus.bcd       = bcd_reg;
  assign bus.busy      = busy_reg;
endmodule

// File: tb/tb_product_bcd_converter.sv
// Self-checking bench for product_bcd_converter: a streamed vector table, then backpressure, ignored-input and mid-shift reset sequences.
// Expected results are queued at acceptance and compared at each result handshake.
module tb_product_bcd_converter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  product_bcd_converter_if #(.IN_W(8), .DIGITS(3)) bus();

  product_bcd_converter #(.IN_W(8), .DIGITS(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [7:0]  din;
    logic [11:0] want_plain;
    logic [11:0] want_blank;
  } vec_t;

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          acc_cyc  = -1;
  logic [11:0] sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] pick(input logic [11:0] plain, input logic [11:0] blank);
`ifdef BCD_BLANK_LEADING_ZERO_EN
    return blank;
`else
    return plain;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, want);
    end
  endtask

  // Scoreboard monitor; samples one time unit after the falling edge.
  logic prev_valid = 1'b0;
  logic hs_prev    = 1'b0;
  initial begin
    logic [11:0] want;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        prev_valid = 1'b0;
        hs_prev    = 1'b0;
      end else begin
        if (hs_prev) check("ready_after_hs", bus.in_ready, 1);
        if (bus.out_valid && !prev_valid && acc_cyc >= 0)
          check("latency", cyc - acc_cyc - 1, 8);
        hs_prev = bus.out_valid && bus.out_ready;
        if (hs_prev) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output actual=%h required=none", bus.bcd);
          end else begin
            want = sb.pop_front();
            check("bcd", bus.bcd, want);
            $display("xfer bcd=%h expected=%h", bus.bcd, want);
          end
        end
        prev_valid = bus.out_valid;
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic [11:0] want, output int at);
    bit ok;
    ok = 1'b0;
    at = -1;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int n = 0; n < 60 && !ok; n++) begin
      #1;
      if (bus.in_ready) begin
        ok      = 1'b1;
        acc_cyc = cyc;
        at      = cyc;
        sb.push_back(want);
        @(posedge clk);
      end else begin
        @(negedge clk);
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=no_accept required=accept data=%0d", d);
    end
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 300 && sb.size() != 0; n++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d_pending required=0", sb.size());
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  vec_t vecs[10];

  initial begin
    int          at;
    int          prev_at;
    logic [11:0] held;

    vecs[0] = '{8'd255, 12'h255, 12'h255};
    vecs[1] = '{8'd225, 12'h225, 12'h225};
    vecs[2] = '{8'd0,   12'h000, 12'hFF0};
    vecs[3] = '{8'd7,   12'h007, 12'hFF7};
    vecs[4] = '{8'd1,   12'h001, 12'hFF1};
    vecs[5] = '{8'd64,  12'h064, 12'hF64};
    vecs[6] = '{8'd128, 12'h128, 12'h128};
    vecs[7] = '{8'd144, 12'h144, 12'h144};
    vecs[8] = '{8'd10,  12'h010, 12'hF10};
    vecs[9] = '{8'd100, 12'h100, 12'h100};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_in_ready",  bus.in_ready,  1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy",      bus.busy,      0);
    check("rst_bcd",       bus.bcd,       0);
    @(negedge clk);
    rst = 1'b0;

    // Streaming with out_ready tied high: accepts must land every 10 cycles.
    prev_at = -1;
    for (int i = 0; i < 10; i++) begin
      send(vecs[i].din, pick(vecs[i].want_plain, vecs[i].want_blank), at);
      if (i > 0) check("accept_spacing", at - prev_at, 10);
      prev_at = at;
    end
    wait_drain();

    // Backpressure, with a new input offered during SHIFT that must be ignored.
    bus.out_ready = 1'b0;
    send(8'd45, pick(12'h045, 12'hF45), at);
    repeat (2) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd99;
    for (int n = 0; n < 30 && !bus.out_valid; n++) begin
      @(negedge clk);
      #1;
    end
    check("bp_valid", bus.out_valid, 1);
    held = bus.bcd;
    check("bp_first_bcd", held, pick(12'h045, 12'hF45));
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      check("bp_bcd_stable", bus.bcd,       held);
      check("bp_out_valid",  bus.out_valid, 1);
      check("bp_in_ready",   bus.in_ready,  0);
      check("bp_busy",       bus.busy,      1);
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    send(8'd99, pick(12'h099, 12'hF99), at);
    wait_drain();

    // Reset during the fourth SHIFT cycle aborts the conversion.
    send(8'd200, 12'h200, at);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", bus.out_valid, 0);
    check("mid_rst_in_ready",  bus.in_ready,  1);
    check("mid_rst_bcd",       bus.bcd,       0);
    check("mid_rst_busy",      bus.busy,      0);
    sb.delete();
    acc_cyc = -1;
    @(negedge clk);
    rst = 1'b0;
    send(8'd123, pick(12'h123, 12'h123), at);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/product_bcd_converter.md
# product_bcd_converter

Sequential binary-to-BCD converter that sits directly downstream of the 4x4 sequential multiplier. It accepts an 8-bit product over a valid/ready handshake and converts it with the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It presents packed BCD digits to the seven-segment display driver. The block is fully registered and holds its result under backpressure.

## Interface
- IN_W, default 8: width of the binary input. Legal range is 1..16.
- DIGITS, default 3: number of BCD digits. Must satisfy 10^DIGITS > 2^IN_W - 1; the defaults satisfy this.
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept; high only in IDLE.
- in_data  input  IN_W  unsigned binary value, e.g. the multiplier product.
- out_valid  output  1  bcd holds a finished result.
- out_ready  input  1  consumer accepts the result.
- bcd  output  4*DIGITS  packed digits; digit 0 (units) is in bits [3:0].
- busy  output  1  high in SHIFT or DONE.

## Operation
- **Reset values:** state IDLE, in_ready=1, out_valid=0, busy=0, bcd=0, internal shift register and counter cleared.
- **States:** IDLE, SHIFT, DONE.
- **IDLE:**
  - in_ready=1.
  - On in_valid && in_ready: load bin_reg <= in_data, digit_reg <= 0, count <= 0, go to SHIFT.
  - With in_valid low, remain in IDLE.
- **SHIFT:** per cycle, do the following in this order:
  - Each 4-bit digit of digit_reg that is >= 5 gets +3. The adjust is combinational on the current register value.
  - Shift {digit_reg, bin_reg} left by 1.
  - count <= count + 1.
  - When count == IN_W-1, latch the final digits into bcd and go to DONE.
- **DONE:**
  - out_valid=1; bcd is stable.
  - On out_ready, go to IDLE.
- **Arithmetic:** unsigned only. The add-3 never carries out of a digit, so no digit exceeds 9.
- **Ignored input:** in_valid while busy is ignored and not queued. The upstream stage must hold data until in_ready.
- **Reset mid-operation:** aborts immediately to IDLE, discarding the partial result. out_valid drops asynchronously.
- **Counter width:** $clog2(IN_W)+1 bits; wrap is impossible.

## Timing
- **Acceptance edge (E0):** the edge where in_valid && in_ready is sampled high.
- **Latency:** out_valid rises after edge E0+IN_W, i.e. 8 cycles at default.
- **in_ready:** falls after E0 and stays low through DONE.
- **Result handshake:** completes on the edge where out_valid && out_ready. in_ready is high in the following cycle.
- **No same-cycle reuse:** a new accept cannot occur on the result-handshake edge.
- **Throughput:** with out_ready tied high, a new input can be accepted every IN_W+2 cycles.
- **Backpressure:** with out_ready low, the block stays in DONE indefinitely with bcd and out_valid constant.
- **Output timing:** in_ready is combinational from state; all other outputs are registered.

## Configuration
- **BCD_BLANK_LEADING_ZERO_EN** defined:
  - When bcd is latched, every digit above the most significant nonzero digit is replaced by 4'hF (display-blank code).
  - Digit 0 is never blanked, so an input of 0 shows as a single 0.
- **Macro undefined:** bcd carries raw BCD, including leading zeros.
- **Scope:** the macro changes only the DONE-latch logic; handshake and latency are identical.

## Test plan
- **Maximum value:** in_data=8'hFF, out_ready=1 -> out_valid exactly 8 cycles after accept, bcd=12'h255, then in_ready=1 one cycle later.
- **Multiplier maximum:** in_data=8'd225 (15*15) -> bcd=12'h225.
- **Zero and blanking:**
  - in_data=8'd0 -> bcd=12'h000 without the macro, 12'hFF0 with it.
  - in_data=8'd7 -> 12'hFF7 with the macro.
- **Backpressure and ignored input:**
  - Hold out_ready=0 for 10 cycles after out_valid -> bcd is constant, in_ready=0.
  - Drive in_valid=1 with new data in_data=8'd99 during SHIFT -> ignored.
  - After out_ready=1, the next accept yields 12'h099 (12'hF99 with the macro).
- **Reset mid-SHIFT:** assert rst at SHIFT cycle 4 of in_data=8'd200 -> out_valid=0, in_ready=1, bcd=0 immediately. A following accept of 8'd123 yields 12'h123.
- **Back-to-back streaming:** with out_ready tied high, four inputs {1, 64, 128, 144} -> results {001, 064, 128, 144} (macro off). Consecutive acceptances are spaced exactly 10 cycles apart.
